vga_sync_gen: RTL

//  - Generates 640x480@60Hz VGA timing from the 100 MHz board clock.
//  - Drives hsync/vsync to the connector.
//  - Feeds pixel_x, pixel_y and video_on to the downstream text/font renderer and colour mux.
//  - p_tick marks each 25 MHz pixel slot; downstream logic samples on it.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/pixel_tick_div.sv | 36 +++
 rtl/vga_sync_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60Hz timing constants and the 10-bit screen coordinate type
// shared by the sync generator and the font/text stage.
package vga_timing_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int TICK_DIV_DEF  = 4;

    localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Inclusive window test used for the sync pulse decode.
    function automatic logic in_window(input coord_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-slot strobe: one-clk p_tick every TICK_DIV clks, registered so it is
// low throughout reset even when TICK_DIV is 1.
module pixel_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_p_tick;

    always_comb begin
        w_cnt_next = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end

    // The strobe is registered from the next count so it lines up with the
    // clk in which the counter sits at TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_p_tick <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_p_tick <= (w_cnt_next == LAST);
        end
    end

    assign p_tick = r_p_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters, registered sync and video_on decode.
// Optional frame counter for text blink is enabled with VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int TICK_DIV  = TICK_DIV_DEF
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output coord_t     pixel_x,
    output coord_t     pixel_y
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_LO   = H_DISPLAY + H_FRONT;
    localparam int HS_HI   = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int VS_LO   = V_DISPLAY + V_FRONT;
    localparam int VS_HI   = V_DISPLAY + V_FRONT + V_SYNC - 1;

    localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);

    logic   w_p_tick;
    logic   w_x_last;
    logic   w_y_last;
    coord_t w_x_next;
    coord_t w_y_next;
    coord_t r_x;
    coord_t r_y;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_video_on;

    pixel_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .p_tick (w_p_tick)
    );

    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_p_tick) begin
            if (w_x_last) begin
                w_x_next = '0;
                w_y_next = w_y_last ? '0 : r_y + 1'b1;
            end else begin
                w_x_next = r_x + 1'b1;
            end
        end
    end

    // Decode from the next-state counters so the registered flags change on
    // the same edge as pixel_x/pixel_y.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b1;
        end else begin
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_hsync    <= ~in_window(w_x_next, HS_LO, HS_HI);
            r_vsync    <= ~in_window(w_y_next, VS_LO, VS_HI);
            r_video_on <= (int'(w_x_next) < H_DISPLAY) && (int'(w_y_next) < V_DISPLAY);
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= 8'd0;
        end else if (w_p_tick && w_x_last && w_y_last) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = r_video_on;
    assign p_tick   = w_p_tick;
    assign pixel_x  = r_x;
    assign pixel_y  = r_y;

endmodule
